// File: rtl/de0_nano_rst_seq_if.sv
// Signal bundle between the reset sequencer and the board/SoC side:
// asynchronous board inputs in, registered SoC resets and last-reset cause out.
interface de0_nano_rst_seq_if;
   logic       pll_locked_i;
   logic       btn_n_i;
   logic       wb_rst_o;
   logic       cpu_rst_o;
   logic [1:0] rst_cause_o;

   modport master (
      input  pll_locked_i,
      input  btn_n_i,
      output wb_rst_o,
      output cpu_rst_o,
      output rst_cause_o
   );

   modport slave (
      output pll_locked_i,
      output btn_n_i,
      input  wb_rst_o,
      input  cpu_rst_o,
      input  rst_cause_o
   );
endinterface

// File: rtl/de0_nano_rst_seq.sv
// DE0-Nano reset sequencer: synchronizes PLL lock, debounces the button, then
// releases the Wishbone reset after a stretch and the CPU reset after a stagger.
module de0_nano_rst_seq #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 240000,
   parameter int unsigned STRETCH_CYCLES  = 1024,
   parameter int unsigned STAGGER_CYCLES  = 16
) (
   input  logic               wb_clk_i,
   input  logic               rst_n_i,
   de0_nano_rst_seq_if.master rst_bus
);

   localparam int unsigned SEQ_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES
                                                                       : STAGGER_CYCLES;
   localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
   localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [SEQ_W-1:0] STRETCH_LAST = SEQ_W'(STRETCH_CYCLES - 1);
   localparam logic [SEQ_W-1:0] STAGGER_LAST = SEQ_W'(STAGGER_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_BTN  = 2'b01;
   localparam logic [1:0] CAUSE_LOCK = 2'b10;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      STRETCH,
      STAGGER,
      RUN
   } state_t;

   logic [SYNC_STAGES-1:0] lock_sync;
   logic [SYNC_STAGES-1:0] btn_sync;
   logic                   lock_s;
   logic                   btn_s;

   logic                   btn_db;
   logic [DB_W-1:0]        db_cnt;
   logic                   pressed;

   state_t                 state_q;
   state_t                 state_nxt;
   logic [SEQ_W-1:0]       seq_q;
   logic [SEQ_W-1:0]       seq_nxt;
   logic [1:0]             cause_q;
   logic [1:0]             cause_nxt;
   logic                   wb_rst_q;
   logic                   cpu_rst_q;

   // Lock resets to "not locked", button to "released" (pad is active-low).
   always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lock_sync <= '0;
         btn_sync  <= '1;
      end else begin
         lock_sync <= {lock_sync[SYNC_STAGES-2:0], rst_bus.pll_locked_i};
         btn_sync  <= {btn_sync[SYNC_STAGES-2:0], rst_bus.btn_n_i};
      end
   end

   assign lock_s = lock_sync[SYNC_STAGES-1];
   assign btn_s  = btn_sync[SYNC_STAGES-1];

   always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         btn_db <= 1'b1;
         db_cnt <= '0;
      end else if (btn_s == btn_db) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         btn_db <= btn_s;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   assign pressed = ~btn_db;

   always_comb begin
      state_nxt = state_q;
      seq_nxt   = '0;
      cause_nxt = cause_q;

      case (state_q)
         WAIT_LOCK: begin
            if (lock_s && !pressed) state_nxt = STRETCH;
         end
         STRETCH: begin
            if (seq_q == STRETCH_LAST) state_nxt = STAGGER;
            else                       seq_nxt   = seq_q + 1'b1;
         end
         STAGGER: begin
            if (seq_q == STAGGER_LAST) state_nxt = RUN;
            else                       seq_nxt   = seq_q + 1'b1;
         end
         RUN: begin
            state_nxt = RUN;
         end
         default: begin
            state_nxt = WAIT_LOCK;
         end
      endcase

      // Aborts override normal progress; lock loss takes priority over the button.
      if (state_q != WAIT_LOCK) begin
         if (!lock_s) begin
            state_nxt = WAIT_LOCK;
            seq_nxt   = '0;
            cause_nxt = CAUSE_LOCK;
         end else if (pressed) begin
            state_nxt = WAIT_LOCK;
            seq_nxt   = '0;
            cause_nxt = CAUSE_BTN;
         end
      end
   end

   // Resets are registered from the next state so they change on the same edge as the FSM.
   always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= WAIT_LOCK;
         seq_q     <= '0;
         cause_q   <= CAUSE_POR;
         wb_rst_q  <= 1'b1;
         cpu_rst_q <= 1'b1;
      end else begin
         state_q   <= state_nxt;
         seq_q     <= seq_nxt;
         cause_q   <= cause_nxt;
         wb_rst_q  <= (state_nxt == WAIT_LOCK) || (state_nxt == STRETCH);
         cpu_rst_q <= (state_nxt != RUN);
      end
   end

   assign rst_bus.wb_rst_o    = wb_rst_q;
   assign rst_bus.cpu_rst_o   = cpu_rst_q;
   assign rst_bus.rst_cause_o = cause_q;

   cpu_implies_bus_release: assert property (
      @(posedge wb_clk_i) disable iff (!rst_n_i) !cpu_rst_q |-> !wb_rst_q
   );

endmodule

// File: tb/tb_de0_nano_rst_seq.sv
// Bench for de0_nano_rst_seq: table-driven phases plus hand-written corner sequences,
// expectations queued with their due cycle and compared by a monitor.
module tb_de0_nano_rst_seq;

   logic        clk;
   logic        rst_n;
   int unsigned cyc;
   int unsigned checks;
   int unsigned failures;

   de0_nano_rst_seq_if bus ();

   de0_nano_rst_seq #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (16),
      .STRETCH_CYCLES  (8),
      .STAGGER_CYCLES  (4)
   ) dut (
      .wb_clk_i (clk),
      .rst_n_i  (rst_n),
      .rst_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected output word: {wb_rst_o, cpu_rst_o, rst_cause_o}.
   typedef struct {
      string       name;
      int unsigned at;
      logic [3:0]  want;
   } sb_t;

   typedef struct {
      string       name;
      logic        rst_n;
      logic        lock;
      logic        btn;
      int unsigned len;
      int unsigned e1;
      logic [3:0]  o1;
      int unsigned e2;
      logic [3:0]  o2;
   } vec_t;

   sb_t  sbq[$];
   vec_t vecs[$];

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s cycle=%0d got wb/cpu/cause=%b/%b/%b want %b/%b/%b",
                  name, cyc, got[3], got[2], got[1:0], want[3], want[2], want[1:0]);
      end
   endtask

   function automatic logic [3:0] outs();
      return {bus.wb_rst_o, bus.cpu_rst_o, bus.rst_cause_o};
   endfunction

   task automatic expect_at(input string name, input int unsigned at, input logic [3:0] want);
      sb_t e;
      e.name = name;
      e.at   = at;
      e.want = want;
      sbq.push_back(e);
   endtask

   function automatic vec_t mk(input string name, input logic r, input logic l, input logic b,
                               input int unsigned len, input int unsigned e1, input logic [3:0] o1,
                               input int unsigned e2, input logic [3:0] o2);
      vec_t v;
      v.name = name; v.rst_n = r; v.lock = l; v.btn = b; v.len = len;
      v.e1 = e1; v.o1 = o1; v.e2 = e2; v.o2 = o2;
      return v;
   endfunction

   task automatic drive(input logic r, input logic l, input logic b);
      rst_n            = r;
      bus.pll_locked_i = l;
      bus.btn_n_i      = b;
   endtask

   // Returns 2 time units after the n-th rising edge.
   task automatic wait_edges(input int unsigned n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      sb_t e;
      #1;
      while (sbq.size() > 0 && sbq[0].at <= cyc) begin
         e = sbq.pop_front();
         if (e.at != cyc) begin
            checks++;
            failures++;
            $display("FAIL %s missed: due cycle %0d, now %0d", e.name, e.at, cyc);
         end else begin
            check(e.name, outs(), e.want);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not end by itself, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      checks   = 0;
      failures = 0;
      drive(1'b0, 1'b0, 1'b1);

      //           name           rst lock btn len  e1  o1       e2  o2
      vecs.push_back(mk("por_hold",    1'b0, 1'b0, 1'b1,  3,  3, 4'b1100,  0, 4'b0000));
      vecs.push_back(mk("por_wb",      1'b1, 1'b1, 1'b1, 11, 10, 4'b1100, 11, 4'b0100));
      vecs.push_back(mk("por_cpu",     1'b1, 1'b1, 1'b1, 10,  3, 4'b0100,  4, 4'b0000));
      vecs.push_back(mk("lock_loss",   1'b1, 1'b0, 1'b1,  6,  2, 4'b0000,  3, 4'b1110));
      vecs.push_back(mk("relock_wb",   1'b1, 1'b1, 1'b1, 11, 10, 4'b1110, 11, 4'b0110));
      vecs.push_back(mk("relock_cpu",  1'b1, 1'b1, 1'b1, 10,  3, 4'b0110,  4, 4'b0010));
      vecs.push_back(mk("bounce_lo1",  1'b1, 1'b1, 1'b0, 10, 10, 4'b0010,  0, 4'b0000));
      vecs.push_back(mk("bounce_hi",   1'b1, 1'b1, 1'b1,  2,  2, 4'b0010,  0, 4'b0000));
      vecs.push_back(mk("bounce_lo2",  1'b1, 1'b1, 1'b0, 10, 10, 4'b0010,  0, 4'b0000));
      vecs.push_back(mk("bounce_end",  1'b1, 1'b1, 1'b1, 30, 20, 4'b0010, 30, 4'b0010));
      vecs.push_back(mk("press",       1'b1, 1'b1, 1'b0, 19, 18, 4'b0010, 19, 4'b1101));
      vecs.push_back(mk("press_hold",  1'b1, 1'b1, 1'b0, 20, 20, 4'b1101,  0, 4'b0000));
      vecs.push_back(mk("release_wb",  1'b1, 1'b1, 1'b1, 27, 26, 4'b1101, 27, 4'b0101));
      vecs.push_back(mk("release_cpu", 1'b1, 1'b1, 1'b1, 10,  3, 4'b0101,  4, 4'b0001));

      foreach (vecs[i]) begin
         base = cyc;
         drive(vecs[i].rst_n, vecs[i].lock, vecs[i].btn);
         if (vecs[i].e1 != 0) expect_at(vecs[i].name, base + vecs[i].e1, vecs[i].o1);
         if (vecs[i].e2 != 0) expect_at(vecs[i].name, base + vecs[i].e2, vecs[i].o2);
         wait_edges(vecs[i].len);
      end

      // Async reset mid-STRETCH: lock loss, relock, then pulse rst_n between edges.
      base = cyc;
      drive(1'b1, 1'b0, 1'b1);
      expect_at("async_pre_abort", base + 2, 4'b0001);
      expect_at("async_abort", base + 3, 4'b1110);
      wait_edges(5);
      drive(1'b1, 1'b1, 1'b1);
      wait_edges(4);
      #1 rst_n = 1'b0;
      #1 check("async_in_stretch", outs(), 4'b1100);
      #2 rst_n = 1'b1;
      base = cyc;
      expect_at("async_rel_wb_hold", base + 10, 4'b1100);
      expect_at("async_rel_wb",      base + 11, 4'b0100);
      expect_at("async_rel_cpu_hold", base + 14, 4'b0100);
      expect_at("async_rel_cpu",     base + 15, 4'b0000);
      wait_edges(20);

      // Async reset from RUN, then press and lock loss landing together during STAGGER.
      bus.pll_locked_i = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("async_in_run", outs(), 4'b1100);
      #2 rst_n = 1'b1;
      base = cyc;
      bus.btn_n_i = 1'b0;
      expect_at("simul_stretch", base + 16, 4'b1100);
      expect_at("simul_stagger", base + 17, 4'b0100);
      expect_at("simul_pre",     base + 18, 4'b0100);
      expect_at("simul_abort",   base + 19, 4'b1110);
      wait_edges(6);
      bus.pll_locked_i = 1'b1;
      wait_edges(10);
      bus.pll_locked_i = 1'b0;
      wait_edges(6);

      for (int i = 0; i < 100 && sbq.size() > 0; i++) @(posedge clk);
      #3;
      if (sbq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations never reached", sbq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/de0_nano_rst_seq.md
# de0_nano_rst_seq

Reset sequencer between the board clock generator and the PicoRV32 Wishbone SoC on the DE0-Nano. It synchronizes the PLL-lock indication and debounces a board push-button. It then produces a stretched, synchronously released Wishbone bus reset, followed by a staggered CPU reset, and records the cause of the most recent reset. All SoC reset inputs are driven from this block; the clock generator supplies only the clock and lock status.

## Interface

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each asynchronous input (≥2).
- DEBOUNCE_CYCLES, 240000: consecutive stable cycles needed to accept a button level change (10 ms at 24 MHz; ≥1).
- STRETCH_CYCLES, 1024: cycles wb_rst_o stays asserted after lock is seen and the button is released (≥1).
- STAGGER_CYCLES, 16: cycles between wb_rst_o release and cpu_rst_o release (≥1).

Ports:
- wb_clk_i, input, 1: system clock from the PLL; the only clock.
- rst_n_i, input, 1: asynchronous active-low reset for the whole block.
- pll_locked_i, input, 1: PLL lock, asynchronous to wb_clk_i.
- btn_n_i, input, 1: push-button, active-low, raw pad, bouncing.
- wb_rst_o, output, 1: Wishbone bus/peripheral reset, active-high.
- cpu_rst_o, output, 1: CPU reset, active-high.
- rst_cause_o, output, 2: cause of last reset entry. 00 = power-on/rst_n_i, 01 = button, 10 = lock loss.

## Operation

- **rst_n_i asserted (asynchronous):**
  - State WAIT_LOCK.
  - wb_rst_o = 1, cpu_rst_o = 1, rst_cause_o = 00.
  - All counters 0.
  - Lock synchronizer chain 0, button synchronizer chain 1.
  - Debounced button = released.
- **Input sync:** pll_locked_i and btn_n_i each pass through SYNC_STAGES flops, giving lock_s and btn_s.
- **Debounce:**
  - Counter increments on each edge where btn_s ≠ btn_db; it clears whenever they are equal.
  - When the count reaches DEBOUNCE_CYCLES−1 and they still differ, btn_db takes btn_s and the counter clears.
  - "pressed" = btn_db low.
- **FSM states:**
  - **WAIT_LOCK:** seq counter held at 0. Moves to STRETCH when lock_s = 1 and not pressed.
  - **STRETCH:** seq counter increments each cycle. Moves to STAGGER at the edge where counter = STRETCH_CYCLES−1; the counter clears on that edge.
  - **STAGGER:** seq counter increments. Moves to RUN at the edge where counter = STAGGER_CYCLES−1.
  - **RUN:** stays until an abort.
- **Abort (any state except WAIT_LOCK):**
  - lock_s = 0 → WAIT_LOCK, rst_cause_o = 10.
  - Otherwise pressed → WAIT_LOCK, rst_cause_o = 01.
  - If both hold in the same cycle, lock loss wins (cause 10).
  - rst_cause_o changes only on abort or rst_n_i.
- **Outputs are registered from the next state:**
  - wb_rst_o = 1 iff next state ∈ {WAIT_LOCK, STRETCH}.
  - cpu_rst_o = 1 iff next state ≠ RUN.
  - Consequence: reset assertion on abort is visible on the same edge as the state change. Both outputs rise together, and they never glitch.
- **Invariant:** cpu_rst_o = 0 implies wb_rst_o = 0. The CPU is never out of reset while the bus is in reset.
- **Counter widths:**
  - Seq counter width is $clog2(max(STRETCH_CYCLES, STAGGER_CYCLES)+1).
  - Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Counters never wrap; terminal compares are exact.

## Timing

- **Release latency:** pll_locked_i goes high and stays high with the button released; edge 1 is the first edge that samples it high.
  - lock_s = 1 after edge SYNC_STAGES.
  - STRETCH entered at edge SYNC_STAGES+1.
  - wb_rst_o falls at edge SYNC_STAGES+1+STRETCH_CYCLES.
  - cpu_rst_o falls STAGGER_CYCLES edges later.
- **Lock-loss latency:** pll_locked_i drops (edge 1 first samples it low), so lock_s = 0 after edge SYNC_STAGES. wb_rst_o and cpu_rst_o rise at edge SYNC_STAGES+1.
- **Button latency:** btn_n_i goes low cleanly (edge 1 first samples it low), so btn_s = 0 after edge SYNC_STAGES. btn_db = 0 at edge SYNC_STAGES+DEBOUNCE_CYCLES, and both resets rise at the following edge.
- **Bounce:** any btn_s toggle back before DEBOUNCE_CYCLES consecutive differing edges resets the count; no reset results.
- **Button held:** the block stays in WAIT_LOCK. Release is debounced identically, then the full STRETCH/STAGGER sequence runs.
- **rst_n_i mid-sequence:** rst_n_i asserted at any point forces reset values immediately, without waiting for a clock edge. On deassertion the sequence restarts from WAIT_LOCK.

## Test plan

All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=16, STRETCH_CYCLES=8, STAGGER_CYCLES=4.

- **Power-up:** rst_n_i low 3 cycles then high, pll_locked_i high at first edge, btn_n_i=1 → wb_rst_o falls at edge 11, cpu_rst_o at edge 15. Outputs are 1/1 before that, and rst_cause_o=00 throughout.
- **Lock loss in RUN:** pll_locked_i drops → both resets high at edge 3 after the drop, rst_cause_o=10. Relock → wb_rst_o low 11 edges and cpu_rst_o low 15 edges after relock.
- **Bounce rejection:** in RUN, btn_n_i low 10 cycles, high 2, low 10, then high → no reset assertion, rst_cause_o unchanged.
- **Clean press:** in RUN, btn_n_i low and held → resets rise at edge 19, rst_cause_o=01. Release → resets stay high until release debounce plus 8 stretch edges, then the 4-edge stagger.
- **Simultaneous abort:** during STAGGER, lock loss and debounced press land on the same edge → WAIT_LOCK, rst_cause_o=10, wb_rst_o re-asserted.
- **Async reset mid-STRETCH:** rst_n_i pulsed low between edges → outputs 1/1 and rst_cause_o=00 before the next edge. After release, full release latency is measured again.
